// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide unit for the execute stage: radix-2 Booth multiply,
// non-restoring divide on magnitudes, one iteration per clock, registered outputs.
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start_mul, start_div, last_iter;

  // Shared datapath: hi is the Booth accumulator or the partial remainder (two guard bits),
  // lo is the multiplier or the dividend/quotient shift register, mcand is multiplicand or |divisor|.
  logic [WIDTH+1:0] hi, mcand;
  logic [WIDTH-1:0] lo;
  logic             q_m1;
  logic             neg_q, div_zero, div_ovf;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH+1:0]   b_sum, b_hi;
  logic [WIDTH-1:0]   b_lo;
  logic [2*WIDTH-1:0] prod;
  logic               mul_ovf;
  logic [WIDTH+1:0]   d_shift, d_rem;
  logic [WIDTH-1:0]   d_quo, d_res;

  assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_mul = 1'b0;
    start_div = 1'b0;
    last_iter = (cnt == CNT_W'(WIDTH-1));
    case (state)
      IDLE, DONE: begin
        // MULT has priority; a simultaneous DIV request is dropped.
        if (ctrl_MULT) begin
          start_mul = 1'b1;
          state_nxt = MUL_RUN;
        end else if (ctrl_DIV) begin
          start_div = 1'b1;
          state_nxt = DIV_RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      MUL_RUN, DIV_RUN: if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth step: examine {lo[0], q_m1}, add/subtract, then arithmetic shift {hi,lo,q_m1} right.
  always_comb begin
    case ({lo[0], q_m1})
      2'b01:   b_sum = hi + mcand;
      2'b10:   b_sum = hi - mcand;
      default: b_sum = hi;
    endcase
    b_hi    = {b_sum[WIDTH+1], b_sum[WIDTH+1:1]};
    b_lo    = {b_sum[0], lo[WIDTH-1:1]};
    prod    = {b_hi[WIDTH-1:0], b_lo};
    mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
  end

  // Non-restoring step: quotient bit is 1 when the new partial remainder is non-negative.
  always_comb begin
    d_shift = {hi[WIDTH:0], lo[WIDTH-1]};
    d_rem   = hi[WIDTH+1] ? (d_shift + mcand) : (d_shift - mcand);
    d_quo   = {lo[WIDTH-2:0], ~d_rem[WIDTH+1]};
    if (div_zero)   d_res = '0;
    else if (neg_q) d_res = ~d_quo + 1'b1;
    else            d_res = d_quo;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt            <= '0;
      hi             <= '0;
      lo             <= '0;
      q_m1           <= 1'b0;
      mcand          <= '0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start_mul) begin
        cnt   <= '0;
        busy  <= 1'b1;
        hi    <= '0;
        lo    <= data_operandB;
        q_m1  <= 1'b0;
        mcand <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
      end else if (start_div) begin
        cnt      <= '0;
        busy     <= 1'b1;
        hi       <= '0;
        lo       <= abs_a;
        q_m1     <= 1'b0;
        mcand    <= {2'b00, abs_b};
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
      end else if (state == MUL_RUN) begin
        cnt  <= cnt + 1'b1;
        hi   <= b_hi;
        lo   <= b_lo;
        q_m1 <= lo[0];
        if (last_iter) begin
          busy           <= 1'b0;
          data_resultRDY <= 1'b1;
          data_result    <= prod[WIDTH-1:0];
          data_exception <= mul_ovf;
        end
      end else if (state == DIV_RUN) begin
        cnt <= cnt + 1'b1;
        hi  <= d_rem;
        lo  <= d_quo;
        if (last_iter) begin
          // INT_MIN / -1 yields magnitude 2^31 with positive sign, i.e. INT_MIN itself.
          busy           <= 1'b0;
          data_resultRDY <= 1'b1;
          data_result    <= d_res;
          data_exception <= div_zero | div_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed corner cases, start-handling scenarios and
// random operands compared against plain-arithmetic reference results.
module tb_multdiv_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int n_chk = 0, n_err = 0;

  multdiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit mul,
                                output logic [31:0] r, output logic e);
    longint p;
    logic [63:0] pu;
    int q;
    if (mul) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pu = p;
      r  = pu[31:0];
      e  = !(pu[63:31] == '0 || pu[63:31] == '1);
    end else if (b == 0) begin
      r = '0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = a; e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q; e = 1'b0;
    end
  endfunction

  // Called between edges. Starts an op at the next edge (T), optionally pulses ctrl_DIV for
  // edge T+inject, waits for RDY, checks latency/busy/result, optionally checks the idle cycle after.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit m, input bit d, input int inject, input bit post);
    logic [31:0] er;
    logic        ee;
    int n, lows;
    model(a, b, m, er, ee);
    data_operandA = a; data_operandB = b; ctrl_MULT = m; ctrl_DIV = d;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;  // must not disturb the latched op
    chk({tag, ".busy_T"}, {63'd0, busy}, 64'd1);
    n = 0; lows = 0;
    while (n < 40) begin
      ctrl_DIV = (inject > 0 && n + 1 == inject);
      @(posedge clock); #1;
      n++;
      ctrl_DIV = 1'b0;
      if (data_resultRDY) break;
      if (!busy) lows++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd32);
    chk({tag, ".busy_run"}, 64'(lows), 64'd0);
    chk({tag, ".result"}, {32'd0, data_result}, {32'd0, er});
    chk({tag, ".exc"}, {63'd0, data_exception}, {63'd0, ee});
    chk({tag, ".busy_done"}, {63'd0, busy}, 64'd0);
    if (post) begin
      @(posedge clock); #1;
      chk({tag, ".rdy_pulse"}, {63'd0, data_resultRDY}, 64'd0);
      chk({tag, ".hold"}, {32'd0, data_result}, {32'd0, er});
    end
  endtask

  initial begin
    logic [31:0] ra, rb, pick;
    int rdys;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.result", {32'd0, data_result}, 64'd0);
    chk("rst.exc", {63'd0, data_exception}, 64'd0);
    chk("rst.rdy", {63'd0, data_resultRDY}, 64'd0);
    chk("rst.busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("mul_7x-3",   32'd7,          32'hFFFF_FFFD, 1, 0, 0, 1);
    run_op("mul_ovf",    32'h0001_0000,  32'h0001_0000, 1, 0, 0, 1);
    run_op("mul_max",    32'h7FFF_FFFF,  32'd1,         1, 0, 0, 1);
    run_op("mul_minx-1", 32'h8000_0000,  32'hFFFF_FFFF, 1, 0, 0, 1);
    run_op("div_-7/2",   32'hFFFF_FFF9,  32'd2,         0, 1, 0, 1);
    run_op("div_7/-2",   32'd7,          32'hFFFF_FFFE, 0, 1, 0, 1);
    run_op("div_100/7",  32'd100,        32'd7,         0, 1, 0, 1);
    run_op("div_min/2",  32'h8000_0000,  32'd2,         0, 1, 0, 1);
    run_op("div_5/0",    32'd5,          32'd0,         0, 1, 0, 1);
    run_op("div_min/-1", 32'h8000_0000,  32'hFFFF_FFFF, 0, 1, 0, 1);
    run_op("div_0/5",    32'd0,          32'd5,         0, 1, 0, 1);
    run_op("div_min/min",32'h8000_0000,  32'h8000_0000, 0, 1, 0, 1);

    run_op("div_ignored", 32'd1234, 32'hFFFF_FF00, 1, 0, 5, 1);
    run_op("b2b_first",   32'd11,   32'd13,        1, 0, 0, 0);
    run_op("b2b_second",  32'hFFFF_FFF0, 32'd3,    1, 0, 0, 1);
    run_op("both_start",  32'd9,    32'd4,         1, 1, 0, 1);

    for (int i = 0; i < 24; i++) begin
      pick = $urandom_range(0, 7);
      ra = (pick == 0) ? 32'h8000_0000 : $urandom;
      rb = (pick == 1) ? 32'd0 : (pick == 2) ? 32'hFFFF_FFFF :
           (pick == 3) ? ($urandom & 32'h0000_FFFF) : $urandom;
      run_op($sformatf("rnd%0d", i), ra, rb, i[0], ~i[0], 0, 1);
    end

    // Abort a divide with reset at edge T+10.
    data_operandA = 32'd1000; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort.busy", {63'd0, busy}, 64'd0);
    chk("abort.result", {32'd0, data_result}, 64'd0);
    chk("abort.exc", {63'd0, data_exception}, 64'd0);
    rdys = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdys++;
    end
    chk("abort.no_rdy", 64'(rdys), 64'd0);
    run_op("after_abort", 32'd3, 32'd4, 1, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end
endmodule
